alu_seq: RTL and testbench

Multi-cycle 8-bit execution unit sitting directly downstream of the 8×8 register file. It consumes the two register read ports as operands and runs one of eight operations, some over several clock cycles. It returns an 8-bit result plus a one-cycle write-enable pulse, which feed back into the register file's write data and write enable. Shifts and multiply are iterative, one bit per cycle, to keep the datapath small.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle 8-bit execution unit feeding the register file write port.
// Optional multiplier (MULL/MULH) is built only when ALU_MUL_EN is defined.
module alu_seq (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] Op,
  input  logic [7:0] InA,
  input  logic [7:0] InB,
  output logic       Busy,
  output logic       Done,
  output logic       Wen,
  output logic [7:0] Result,
  output logic       Flag
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_MULL = 3'd6;
  localparam logic [2:0] OP_MULH = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, nxt;
  logic [2:0] op_q;
  logic [7:0] a_q;   // operand A; also the shift working value
  logic [7:0] b_q;   // operand B; also the multiplier shifted right per step
  logic [2:0] cnt;
  logic       sbit;  // last bit shifted out
  logic       fin;
  logic [7:0] res_n;
  logic       flg_n;

`ifdef ALU_MUL_EN
  logic [15:0] acc;
  logic [15:0] mul_nxt;
  logic [8:0]  msum;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt   = state;
    fin   = 1'b0;
    res_n = 8'h00;
    flg_n = 1'b0;
`ifdef ALU_MUL_EN
    // right-shifting shift-add: upper half accumulates, low bits shift in
    msum    = {1'b0, acc[15:8]} + (b_q[0] ? {1'b0, a_q} : 9'd0);
    mul_nxt = {msum, acc[7:1]};
`endif
    case (state)
      IDLE: if (Start) nxt = RUN;
      RUN: begin
        case (op_q)
          OP_ADD: begin
            fin = 1'b1;
            {flg_n, res_n} = {1'b0, a_q} + {1'b0, b_q};
          end
          OP_SUB: begin
            fin   = 1'b1;
            res_n = a_q - b_q;
            flg_n = (a_q < b_q);
          end
          OP_AND: begin
            fin   = 1'b1;
            res_n = a_q & b_q;
          end
          OP_XOR: begin
            fin   = 1'b1;
            res_n = a_q ^ b_q;
          end
          OP_SHL, OP_SHR: begin
            fin   = (cnt == 3'd0);
            res_n = a_q;
            flg_n = sbit;
          end
          OP_MULL, OP_MULH: begin
`ifdef ALU_MUL_EN
            fin   = (cnt == 3'd0);
            res_n = (op_q == OP_MULL) ? mul_nxt[7:0] : mul_nxt[15:8];
            flg_n = (op_q == OP_MULL) && (mul_nxt[15:8] != 8'h00);
`else
            fin   = 1'b1;
            res_n = 8'h00;
            flg_n = 1'b1;
`endif
          end
          default: ;
        endcase
        if (fin) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q   <= 3'd0;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      cnt    <= 3'd0;
      sbit   <= 1'b0;
      Result <= 8'h00;
      Flag   <= 1'b0;
`ifdef ALU_MUL_EN
      acc    <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: if (Start) begin
          op_q <= Op;
          a_q  <= InA;
          b_q  <= InB;
          sbit <= 1'b0;
          cnt  <= (Op[2:1] == 2'b11) ? 3'd7 : InB[2:0];
`ifdef ALU_MUL_EN
          acc  <= 16'h0000;
`endif
        end
        RUN: begin
          if (fin) begin
            Result <= res_n;
            Flag   <= flg_n;
          end else begin
            cnt <= cnt - 3'd1;
            case (op_q)
              OP_SHL: {sbit, a_q} <= {a_q, 1'b0};
              OP_SHR: {a_q, sbit} <= {1'b0, a_q};
`ifdef ALU_MUL_EN
              OP_MULL, OP_MULH: begin
                acc <= mul_nxt;
                b_q <= {1'b0, b_q[7:1]};
              end
`endif
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
    Wen  = (state == DONE);
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [2:0] Op = 3'd0;
  logic [7:0] InA = 8'h00;
  logic [7:0] InB = 8'h00;
  logic       Busy, Done, Wen, Flag;
  logic [7:0] Result;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] prev_res = 8'h00;
  logic       prev_flg = 1'b0;

  alu_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .InA(InA), .InB(InB),
    .Busy(Busy), .Done(Done), .Wen(Wen), .Result(Result), .Flag(Flag)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result, flag and Done cycle from the operation rules.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic f, output int lat);
    int k, s;
    k   = int'(b[2:0]);
    lat = 2;
    f   = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); f = (s > 255); end
      3'd1: begin s = int'(a) - int'(b); r = 8'((s + 256) % 256); f = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: begin
        s = int'(a) * (1 << k);
        r = 8'(s % 256);
        f = (k != 0) && (((s / 256) % 2) == 1);
        lat = 2 + k;
      end
      3'd5: begin
        r = 8'(int'(a) / (1 << k));
        f = (k != 0) && (((int'(a) / (1 << (k - 1))) % 2) == 1);
        lat = 2 + k;
      end
      default: begin
`ifdef ALU_MUL_EN
        s   = int'(a) * int'(b);
        lat = 9;
        if (op == 3'd6) begin r = 8'(s % 256); f = (s >= 256); end
        else            begin r = 8'(s / 256); f = 1'b0; end
`else
        r = 8'h00;
        f = 1'b1;
`endif
      end
    endcase
  endfunction

  // Start an op in the next IDLE cycle; hold keeps Start high with junk operands.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit hold);
    logic [7:0] er;
    logic       ef;
    int         lat, n;
    bit         seen;
    model(op, a, b, er, ef, lat);
    @(negedge Clk);
    chk("idle_before_start", 32'(Busy), 32'd0);
    Start = 1'b1; Op = op; InA = a; InB = b;
    seen = 0;
    n = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge Clk);
      n = c;
      if (c == 1) begin
        chk("busy_cycle1", 32'(Busy), 32'd1);
        chk("result_held", 32'(Result), 32'(prev_res));
        chk("flag_held", 32'(Flag), 32'(prev_flg));
      end
      if (Done) seen = 1;
      else if (c > 1) chk("busy_running", 32'(Busy), 32'd1);
      Start = hold;
      Op  = 3'($urandom_range(0, 7));
      InA = 8'($urandom);
      InB = 8'($urandom);
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk($sformatf("lat_op%0d", op), 32'(n), 32'(lat));
    chk($sformatf("res_op%0d_%02h_%02h", op, a, b), 32'(Result), 32'(er));
    chk($sformatf("flag_op%0d_%02h_%02h", op, a, b), 32'(Flag), 32'(ef));
    chk("wen_eq_done", 32'(Wen), 32'd1);
    chk("busy_in_done", 32'(Busy), 32'd1);
    prev_res = er;
    prev_flg = ef;
  endtask

  initial begin
    logic [2:0] long_op;
    logic [7:0] long_b;
    int wen_seen;
`ifdef ALU_MUL_EN
    long_op = 3'd6; long_b = 8'h11;
`else
    long_op = 3'd4; long_b = 8'h07;
`endif
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_wen", 32'(Wen), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_flag", 32'(Flag), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op(3'd0, 8'hF0, 8'h20, 0);
    run_op(3'd1, 8'h05, 8'h07, 0);
    run_op(3'd4, 8'h81, 8'h03, 0);
    run_op(3'd5, 8'h81, 8'h01, 0);
    run_op(3'd4, 8'h5A, 8'h00, 0);
    run_op(3'd5, 8'hA5, 8'hF8, 0);
    run_op(3'd6, 8'h0F, 8'h11, 0);
    run_op(3'd6, 8'hFF, 8'hFF, 0);
    run_op(3'd7, 8'hFF, 8'hFF, 0);
    run_op(3'd7, 8'h0F, 8'h11, 0);

    // Continuous Start during a long op; next op must start right after Done.
    run_op(long_op, 8'h0F, long_b, 1);
    run_op(3'd3, 8'h3C, 8'hFF, 0);

    // Asynchronous reset in cycle 4 of a long op.
    @(negedge Clk);
    Start = 1'b1; Op = long_op; InA = 8'hFF; InB = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    #2 Reset = 1'b1;
    #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    chk("arst_wen", 32'(Wen), 32'd0);
    chk("arst_result", 32'(Result), 32'd0);
    chk("arst_flag", 32'(Flag), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    prev_res = 8'h00;
    prev_flg = 1'b0;
    wen_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (Wen || Busy) wen_seen++;
    end
    chk("no_wen_after_abort", 32'(wen_seen), 32'd0);
    run_op(3'd0, 8'h01, 8'h02, 0);

    for (int i = 0; i < 150; i++)
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
